// File: rtl/starflux_pkg.sv
// Shared game-logic definitions: game-state encoding, gun heat width and the
// enemy-hit popcount helper.
package starflux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int HEAT_W      = 4;
  localparam int MAX_ENEMIES = 8;

  function automatic logic [3:0] popcount(input logic [MAX_ENEMIES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_ENEMIES; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/logic_handler_multi_if.sv
// Game-logic bus: control strobes and hit pulses in, ship/enemy/gun/score
// state out. master = control side, slave = logic_handler_multi.
interface logic_handler_multi_if #(
  parameter int SCREEN_W    = 160,
  parameter int NUM_ENEMIES = 4,
  parameter int HEALTH_W    = 4,
  parameter int SCORE_W     = 8
);
  import starflux_pkg::*;

  localparam int X_W = $clog2(SCREEN_W);

  logic                       right;
  logic                       left;
  logic                       shoot;
  logic                       startGameEn;
  logic                       shipUpdateEn;
  logic                       gridUpdateEn;
  logic [NUM_ENEMIES-1:0]     enemy_hit;
  logic                       user_hit;

  logic [X_W-1:0]             user_x;
  logic [NUM_ENEMIES*X_W-1:0] enemy_x;
  logic                       fire;
  logic [HEAT_W-1:0]          gun_cooldown;
  logic                       overheated;
  logic [HEALTH_W-1:0]        ship_health;
  logic [SCORE_W-1:0]         current_score;
  logic [SCORE_W-1:0]         alltime_highscore;
  logic [1:0]                 game_state;
  logic                       invuln;

  modport master (
    output right, left, shoot, startGameEn, shipUpdateEn, gridUpdateEn,
           enemy_hit, user_hit,
    input  user_x, enemy_x, fire, gun_cooldown, overheated, ship_health,
           current_score, alltime_highscore, game_state, invuln
  );

  modport slave (
    input  right, left, shoot, startGameEn, shipUpdateEn, gridUpdateEn,
           enemy_hit, user_hit,
    output user_x, enemy_x, fire, gun_cooldown, overheated, ship_health,
           current_score, alltime_highscore, game_state, invuln
  );

endinterface

// File: rtl/enemy_patrol.sv
// One bouncing enemy: x position plus travel direction, reversing at the
// screen edges (0 and XMAX) with a 1 px inward step on the same tick.
module enemy_patrol #(
  parameter int X_W        = 8,
  parameter int XMAX       = 152,
  parameter int INIT_X     = 0,
  parameter bit INIT_RIGHT = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           init,
  input  logic           step,
  output logic [X_W-1:0] x
);

  logic right_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      x       <= '0;
      right_q <= 1'b0;
    end else if (init) begin
      x       <= X_W'(INIT_X);
      right_q <= INIT_RIGHT;
    end else if (step) begin
      if (right_q) begin
        if (x >= X_W'(XMAX)) begin
          right_q <= 1'b0;
          x       <= x - X_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end else begin
        if (x == '0) begin
          right_q <= 1'b1;
          x       <= X_W'(1);
        end else begin
          x <= x - X_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/logic_handler_multi.sv
// Game-logic core: game FSM, ship, bouncing enemies, gun heat, score/health.
// Optional post-hit immunity window enabled by LOGIC_HANDLER_INVULN_EN.
module logic_handler_multi
  import starflux_pkg::*;
#(
  parameter int SCREEN_W     = 160,
  parameter int SHIP_W       = 8,
  parameter int NUM_ENEMIES  = 4,
  parameter int STEP         = 2,
  parameter int MAX_HEALTH   = 8,
  parameter int HEALTH_W     = 4,
  parameter int SCORE_W      = 8,
  parameter int COOL_MAX     = 15,
`ifdef LOGIC_HANDLER_INVULN_EN
  parameter int HEAT_STEP    = 3,
  parameter int INVULN_TICKS = 30
`else
  parameter int HEAT_STEP    = 3
`endif
) (
  input logic                  clk,
  input logic                  reset,
  logic_handler_multi_if.slave bus
);

  localparam int X_W     = $clog2(SCREEN_W);
  localparam int XMAX    = SCREEN_W - SHIP_W;
  localparam int SPACING = SCREEN_W / NUM_ENEMIES;

  game_state_t         state_q, state_d;
  logic [X_W-1:0]      user_x_q, x_next;
  logic [X_W:0]        x_plus;
  logic                fire_q;
  logic [HEAT_W-1:0]   heat_q, heat_add;
  logic [HEAT_W:0]     heat_sum;
  logic                ovh_q;
  logic [HEALTH_W-1:0] health_q;
  logic [SCORE_W-1:0]  score_q, high_q, score_sat;
  logic [SCORE_W:0]    score_sum;
  logic                invuln_q;
  logic                playing, ship_tick, grid_tick, hit_ok;

  // startGameEn outranks every tick and hit in the same cycle.
  assign playing   = (state_q == PLAY) && !bus.startGameEn;
  assign ship_tick = playing && bus.shipUpdateEn;
  assign grid_tick = playing && bus.gridUpdateEn;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assigned first so no latch is inferred on unlisted paths.
    state_d = state_q;
    if (bus.startGameEn)                        state_d = PLAY;
    else if (state_q == PLAY && health_q == '0) state_d = OVER;
  end

  assign x_plus   = {1'b0, user_x_q} + (X_W+1)'(STEP);
  assign heat_sum = {1'b0, heat_q} + (HEAT_W+1)'(HEAT_STEP);
  assign heat_add = (heat_sum > (HEAT_W+1)'(COOL_MAX)) ? HEAT_W'(COOL_MAX)
                                                       : heat_sum[HEAT_W-1:0];
  assign score_sum = {1'b0, score_q}
                   + (SCORE_W+1)'(popcount(MAX_ENEMIES'(bus.enemy_hit)));
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  always_comb begin
    x_next = user_x_q;
    if (bus.right && !bus.left) begin
      x_next = (x_plus > (X_W+1)'(XMAX)) ? X_W'(XMAX) : x_plus[X_W-1:0];
    end else if (bus.left && !bus.right) begin
      x_next = (user_x_q < X_W'(STEP)) ? '0 : user_x_q - X_W'(STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      user_x_q <= '0;
      fire_q   <= 1'b0;
      heat_q   <= '0;
      ovh_q    <= 1'b0;
      health_q <= '0;
      score_q  <= '0;
      high_q   <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees last cycle's values.
      fire_q <= 1'b0;
      if (score_q > high_q) high_q <= score_q;
      if (bus.startGameEn) begin
        user_x_q <= X_W'(XMAX / 2);
        heat_q   <= '0;
        ovh_q    <= 1'b0;
        health_q <= HEALTH_W'(MAX_HEALTH);
        score_q  <= '0;
      end else if (state_q == PLAY) begin
        score_q <= score_sat;
        if (hit_ok && health_q != '0) health_q <= health_q - HEALTH_W'(1);
        if (ship_tick) begin
          user_x_q <= x_next;
          if (bus.shoot && !ovh_q) begin
            fire_q <= 1'b1;
            heat_q <= heat_add;
            if (heat_add == HEAT_W'(COOL_MAX)) ovh_q <= 1'b1;
          end else begin
            if (heat_q != '0) heat_q <= heat_q - HEAT_W'(1);
            if (heat_q <= HEAT_W'(1)) ovh_q <= 1'b0;
          end
        end
      end
    end
  end

`ifdef LOGIC_HANDLER_INVULN_EN
  localparam int TMR_W = $clog2(INVULN_TICKS + 1);
  logic [TMR_W-1:0] timer_q;

  assign hit_ok = playing && bus.user_hit && !invuln_q;

  // An accepted hit reloads the window even if a ship tick lands the same cycle.
  always_ff @(posedge clk) begin
    if (reset || bus.startGameEn) begin
      timer_q  <= '0;
      invuln_q <= 1'b0;
    end else if (hit_ok) begin
      timer_q  <= TMR_W'(INVULN_TICKS);
      invuln_q <= 1'b1;
    end else if (ship_tick && invuln_q) begin
      timer_q <= timer_q - TMR_W'(1);
      if (timer_q <= TMR_W'(1)) invuln_q <= 1'b0;
    end
  end
`else
  assign hit_ok   = playing && bus.user_hit;
  assign invuln_q = 1'b0;
`endif

  for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_enemy
    localparam int RAW_X = i * SPACING;
    enemy_patrol #(
      .X_W        (X_W),
      .XMAX       (XMAX),
      .INIT_X     ((RAW_X > XMAX) ? XMAX : RAW_X),
      .INIT_RIGHT ((i % 2) == 0)
    ) u_enemy (
      .clk   (clk),
      .reset (reset),
      .init  (bus.startGameEn),
      .step  (grid_tick),
      .x     (bus.enemy_x[i*X_W +: X_W])
    );
  end

  assign bus.user_x            = user_x_q;
  assign bus.fire              = fire_q;
  assign bus.gun_cooldown      = heat_q;
  assign bus.overheated        = ovh_q;
  assign bus.ship_health       = health_q;
  assign bus.current_score     = score_q;
  assign bus.alltime_highscore = high_q;
  assign bus.game_state        = state_q;
  assign bus.invuln            = invuln_q;

endmodule

// File: tb/tb_logic_handler_multi.sv
// Self-checking bench for logic_handler_multi: directed scenarios plus random
// traffic, all outputs compared every cycle against a behavioural game model.
module tb_logic_handler_multi;

  localparam int SCREEN_W     = 160;
  localparam int SHIP_W       = 8;
  localparam int NE           = 4;
  localparam int STEP         = 2;
  localparam int MAX_HEALTH   = 8;
  localparam int HEALTH_W     = 4;
  localparam int SCORE_W      = 8;
  localparam int COOL_MAX     = 15;
  localparam int HEAT_STEP    = 3;
  localparam int INVULN_TICKS = 30;
  localparam int X_W          = $clog2(SCREEN_W);
  localparam int XMAX         = SCREEN_W - SHIP_W;
  localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  bit   cmp_en = 1'b0;

  logic_handler_multi_if #(
    .SCREEN_W(SCREEN_W), .NUM_ENEMIES(NE), .HEALTH_W(HEALTH_W), .SCORE_W(SCORE_W)
  ) bus ();

  logic_handler_multi #(
    .SCREEN_W(SCREEN_W), .SHIP_W(SHIP_W), .NUM_ENEMIES(NE), .STEP(STEP),
    .MAX_HEALTH(MAX_HEALTH), .HEALTH_W(HEALTH_W), .SCORE_W(SCORE_W),
    .COOL_MAX(COOL_MAX), .HEAT_STEP(HEAT_STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  int m_state, m_x, m_heat, m_ovh, m_fire, m_hp, m_score, m_hi, m_inv, m_tmr;
  int m_ex [NE];
  int m_v  [NE];

  always @(posedge clk) begin : model
    int old_score, old_hp, nx;
    if (reset) begin
      m_state = 0; m_x = 0; m_heat = 0; m_ovh = 0; m_fire = 0;
      m_hp = 0; m_score = 0; m_hi = 0; m_inv = 0; m_tmr = 0;
      for (int i = 0; i < NE; i++) begin m_ex[i] = 0; m_v[i] = 1; end
    end else begin
      old_score = m_score;
      old_hp    = m_hp;
      m_fire    = 0;
      if (bus.startGameEn) begin
        m_state = 1; m_x = XMAX / 2; m_hp = MAX_HEALTH; m_score = 0;
        m_heat = 0; m_ovh = 0; m_inv = 0; m_tmr = 0;
        for (int i = 0; i < NE; i++) begin
          m_ex[i] = (i * (SCREEN_W / NE) > XMAX) ? XMAX : i * (SCREEN_W / NE);
          m_v[i]  = (i % 2 == 0) ? 1 : -1;
        end
      end else if (m_state == 1) begin
        if (old_hp == 0) m_state = 2;
        if (bus.shipUpdateEn) begin
          if (bus.right && !bus.left)      m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP;
          else if (bus.left && !bus.right) m_x = (m_x - STEP < 0) ? 0 : m_x - STEP;
          if (bus.shoot && m_ovh == 0) begin
            m_fire = 1;
            m_heat = (m_heat + HEAT_STEP > COOL_MAX) ? COOL_MAX : m_heat + HEAT_STEP;
            if (m_heat == COOL_MAX) m_ovh = 1;
          end else begin
            if (m_heat > 0) m_heat--;
            if (m_heat == 0) m_ovh = 0;
          end
        end
        if (bus.gridUpdateEn) begin
          for (int i = 0; i < NE; i++) begin
            nx = m_ex[i] + m_v[i];
            if (nx < 0 || nx > XMAX) begin
              m_v[i] = -m_v[i];
              nx = m_ex[i] + m_v[i];
            end
            m_ex[i] = nx;
          end
        end
        m_score = m_score + $countones(bus.enemy_hit);
        if (m_score > SCORE_MAX) m_score = SCORE_MAX;
`ifdef LOGIC_HANDLER_INVULN_EN
        if (bus.user_hit && m_inv == 0) begin
          if (m_hp > 0) m_hp--;
          m_inv = 1;
          m_tmr = INVULN_TICKS;
        end else if (bus.shipUpdateEn && m_inv == 1) begin
          m_tmr--;
          if (m_tmr == 0) m_inv = 0;
        end
`else
        if (bus.user_hit && m_hp > 0) m_hp--;
`endif
      end
      if (old_score > m_hi) m_hi = old_score;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("user_x", longint'(bus.user_x), m_x);
      for (int i = 0; i < NE; i++)
        check($sformatf("enemy_x[%0d]", i), longint'(bus.enemy_x[i*X_W +: X_W]), m_ex[i]);
      check("fire", longint'(bus.fire), m_fire);
      check("gun_cooldown", longint'(bus.gun_cooldown), m_heat);
      check("overheated", longint'(bus.overheated), m_ovh);
      check("ship_health", longint'(bus.ship_health), m_hp);
      check("current_score", longint'(bus.current_score), m_score);
      check("alltime_highscore", longint'(bus.alltime_highscore), m_hi);
      check("game_state", longint'(bus.game_state), m_state);
      check("invuln", longint'(bus.invuln), m_inv);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ship_ticks(input int n);
    repeat (n) begin
      bus.shipUpdateEn = 1'b1; cycle();
      bus.shipUpdateEn = 1'b0; cycle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.right = 1'b0; bus.left = 1'b0; bus.shoot = 1'b0;
    bus.startGameEn = 1'b0; bus.shipUpdateEn = 1'b0; bus.gridUpdateEn = 1'b0;
    bus.enemy_hit = '0; bus.user_hit = 1'b0;
    cycle();
    cmp_en = 1'b1;
    cycle();
    check("rst game_state", bus.game_state, 0);
    check("rst user_x", bus.user_x, 0);
    check("rst health", bus.ship_health, 0);
    check("rst highscore", bus.alltime_highscore, 0);
    reset = 1'b0;
    cycle();

    // T1: new game
    bus.startGameEn = 1'b1; cycle(); bus.startGameEn = 1'b0;
    check("t1 game_state", bus.game_state, 1);
    check("t1 user_x", bus.user_x, 76);
    check("t1 enemy_x", bus.enemy_x, 64'h7850_2800);
    check("t1 health", bus.ship_health, 8);
    check("t1 score", bus.current_score, 0);

    // T2: ship saturation and conflicting requests
    bus.right = 1'b1; ship_ticks(40);
    check("t2 right sat", bus.user_x, 152);
    bus.left = 1'b1; ship_ticks(3);
    check("t2 both hold", bus.user_x, 152);
    bus.right = 1'b0; ship_ticks(5);
    check("t2 left 5", bus.user_x, 142);
    ship_ticks(80);
    check("t2 left sat", bus.user_x, 0);
    bus.left = 1'b0;

    // T3: gun heat
    bus.shoot = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus.shipUpdateEn = 1'b1; cycle(); bus.shipUpdateEn = 1'b0;
      check("t3 fire pulse", bus.fire, 1);
      check("t3 heat", bus.gun_cooldown, 3 * k);
      cycle();
      check("t3 fire low", bus.fire, 0);
    end
    check("t3 overheated", bus.overheated, 1);
    bus.shoot = 1'b0; ship_ticks(14);
    check("t3 heat 1", bus.gun_cooldown, 1);
    check("t3 still hot", bus.overheated, 1);
    ship_ticks(1);
    check("t3 cooled", bus.gun_cooldown, 0);
    check("t3 unlocked", bus.overheated, 0);

    // T4: score and saturation, high score kept across games
    bus.enemy_hit = 4'b1011; cycle(); bus.enemy_hit = '0;
    check("t4 score 3", bus.current_score, 3);
    bus.enemy_hit = 4'b1111; repeat (63) cycle();
    check("t4 score 255", bus.current_score, 255);
    cycle(); bus.enemy_hit = '0;
    check("t4 score sat", bus.current_score, 255);
    cycle();
    check("t4 high", bus.alltime_highscore, 255);
    bus.startGameEn = 1'b1; cycle(); bus.startGameEn = 1'b0;
    check("t4 new score", bus.current_score, 0);
    check("t4 high kept", bus.alltime_highscore, 255);

`ifdef LOGIC_HANDLER_INVULN_EN
    // T6: immunity window
    bus.user_hit = 1'b1; cycle(); bus.user_hit = 1'b0;
    check("t6 first hit", bus.ship_health, 7);
    check("t6 invuln", bus.invuln, 1);
    ship_ticks(5);
    bus.user_hit = 1'b1; cycle(); bus.user_hit = 1'b0;
    check("t6 ignored", bus.ship_health, 7);
    ship_ticks(25);
    check("t6 window over", bus.invuln, 0);
    bus.user_hit = 1'b1; cycle(); bus.user_hit = 1'b0;
    check("t6 second hit", bus.ship_health, 6);
`else
    // T5: game over
    bus.user_hit = 1'b1; repeat (8) cycle(); bus.user_hit = 1'b0;
    check("t5 health 0", bus.ship_health, 0);
    check("t5 still play", bus.game_state, 1);
    cycle();
    check("t5 over", bus.game_state, 2);
    bus.right = 1'b1; bus.shipUpdateEn = 1'b1; bus.enemy_hit = 4'b1111;
    repeat (3) cycle();
    bus.right = 1'b0; bus.shipUpdateEn = 1'b0; bus.enemy_hit = '0;
    check("t5 x frozen", bus.user_x, 76);
    check("t5 score frozen", bus.current_score, 0);
    bus.startGameEn = 1'b1; bus.user_hit = 1'b1; cycle();
    bus.startGameEn = 1'b0; bus.user_hit = 1'b0;
    check("t5 restart health", bus.ship_health, 8);
    check("t5 restart state", bus.game_state, 1);
`endif

    // Random traffic
    bus.startGameEn = 1'b1; cycle(); bus.startGameEn = 1'b0;
    repeat (3000) begin
      reset            = ($urandom_range(999) == 0);
      bus.startGameEn  = ($urandom_range(299) == 0);
      bus.right        = 1'($urandom_range(1));
      bus.left         = 1'($urandom_range(1));
      bus.shoot        = 1'($urandom_range(1));
      bus.shipUpdateEn = ($urandom_range(2) == 0);
      bus.gridUpdateEn = 1'($urandom_range(1));
      bus.enemy_hit    = ($urandom_range(7) == 0) ? NE'($urandom) : '0;
      bus.user_hit     = ($urandom_range(39) == 0);
      cycle();
    end
    reset = 1'b0;
    bus.startGameEn = 1'b0; bus.shipUpdateEn = 1'b0; bus.gridUpdateEn = 1'b0;
    bus.enemy_hit = '0; bus.user_hit = 1'b0;
    cycle();
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
